// File: rtl/riscv_isa_pkg.sv
// riscv_isa_pkg: shared RV32 opcode, format-class and NOP constants
// Contents: OP_* opcodes, FMT_* format classes (R=0 I=1 S=2 B=3 U=4 J=5 ILL=7), NOP_INSTR
package riscv_isa_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/riscv_imm_gen.sv
// riscv_imm_gen: combinational format classifier and sign-extended immediate generator
// Ports: instruction (32) in; fmt (3), illegal (1), imm (IMM_W) out. Parameter IMM_W >= 32.
module riscv_imm_gen
  import riscv_isa_pkg::*;
#(
  parameter int IMM_W = 64
) (
  input  logic [31:0]      instruction,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [IMM_W-1:0] imm
);
  logic [31:0] i;
  logic signed [31:0] v;
  assign i = instruction;
  always_comb begin
    case (i[6:0])
      OP_R:                      fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:  fmt = FMT_I;
      OP_STORE:                  fmt = FMT_S;
      OP_BRANCH:                 fmt = FMT_B;
      OP_LUI, OP_AUIPC:          fmt = FMT_U;
      OP_JAL:                    fmt = FMT_J;
      default:                   fmt = FMT_ILL;
    endcase
  end
  assign illegal = fmt == FMT_ILL;
  // build a 32-bit signed value first so one cast handles extension to any IMM_W
  assign v = fmt == FMT_I ? {{20{i[31]}}, i[31:20]} :
             fmt == FMT_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
             fmt == FMT_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
             fmt == FMT_U ? {i[31:12], 12'b0} :
             fmt == FMT_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
             32'sd0;
  assign imm = IMM_W'(v);
endmodule

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: flow-controlled IF/ID register with registered decode fields and stall counter
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, instruction_in, pc_in, flush from fetch;
//        out_valid/out_ready, instruction_out, pc_out, ctrl, rd, funct3, rs1, rs2, funct7,
//        fmt, illegal, imm, stall_cnt toward ID. Optional trace: define IF_ID_TRACE_EN.
module if_id_pipe_reg
  import riscv_isa_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int IMM_W = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction_in,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instruction_out,
  output logic [PC_W-1:0]  pc_out,
  output logic [6:0]       ctrl,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       funct7,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [IMM_W-1:0] imm,
  output logic [CNT_W-1:0] stall_cnt
);
  logic accept, hold, nop, ill_d;
  logic [31:0] src;
  logic [2:0] fmt_d;
  logic [IMM_W-1:0] imm_d;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready && !flush;
  assign hold = out_valid && !out_ready;
  // reset and flush both load the NOP through the same decode path
  assign nop = !rst_n || flush;
  assign src = nop ? NOP_INSTR : instruction_in;
  riscv_imm_gen #(.IMM_W(IMM_W)) u_imm_gen (
    .instruction(src),
    .fmt(fmt_d),
    .illegal(ill_d),
    .imm(imm_d)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt <= '0;
    else if (hold && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    if (nop) out_valid <= 1'b0;
    else if (accept) out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
    if (nop || accept) begin
      instruction_out <= src;
      pc_out <= nop ? '0 : pc_in;
      ctrl <= src[6:0];
      rd <= src[11:7];
      funct3 <= src[14:12];
      rs1 <= src[19:15];
      rs2 <= src[24:20];
      funct7 <= src[31:25];
      fmt <= fmt_d;
      illegal <= ill_d;
      imm <= imm_d;
    end
  end
`ifdef IF_ID_TRACE_EN
  function automatic string fmt_name(input logic [2:0] f);
    return f == FMT_R ? "R" : f == FMT_I ? "I" : f == FMT_S ? "S" :
           f == FMT_B ? "B" : f == FMT_U ? "U" : f == FMT_J ? "J" : "ILL";
  endfunction
  always_ff @(posedge clk) begin
    if (rst_n && flush) $display("%0t IF/ID flush", $time);
    else if (rst_n && accept && ill_d)
      $display("%0t IF/ID pc=%h ILL opcode=%b", $time, pc_in, instruction_in[6:0]);
    else if (rst_n && accept)
      $display("%0t IF/ID pc=%h %s rd=%0d rs1=%0d rs2=%0d imm=%0h", $time, pc_in,
               fmt_name(fmt_d), instruction_in[11:7], instruction_in[19:15],
               instruction_in[24:20], imm_d);
  end
`endif
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb_if_id_pipe_reg: directed self-checking bench for if_id_pipe_reg
module tb_if_id_pipe_reg;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, flush = 0;
  logic [31:0] instruction_in = 0;
  logic [7:0] pc_in = 0;
  logic in_ready, out_valid, illegal;
  logic [31:0] instruction_out;
  logic [7:0] pc_out;
  logic [6:0] ctrl, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3, fmt;
  logic [63:0] imm;
  logic [15:0] stall_cnt;
  logic in_ready2, out_valid2, illegal2;
  logic [31:0] instruction_out2;
  logic [7:0] pc_out2;
  logic [6:0] ctrl2, funct7_2;
  logic [4:0] rd2, rs1_2, rs2_2;
  logic [2:0] funct3_2, fmt2;
  logic [63:0] imm2;
  logic [1:0] stall_cnt2;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  if_id_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_in(instruction_in), .pc_in(pc_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .instruction_out(instruction_out),
    .pc_out(pc_out), .ctrl(ctrl), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .fmt(fmt), .illegal(illegal), .imm(imm), .stall_cnt(stall_cnt)
  );

  if_id_pipe_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .instruction_in(instruction_in), .pc_in(pc_in), .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready), .instruction_out(instruction_out2),
    .pc_out(pc_out2), .ctrl(ctrl2), .rd(rd2), .funct3(funct3_2), .rs1(rs1_2), .rs2(rs2_2),
    .funct7(funct7_2), .fmt(fmt2), .illegal(illegal2), .imm(imm2), .stall_cnt(stall_cnt2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0; in_valid = 0; flush = 0; out_ready = 0;
    tick;
    rst_n = 1;
  endtask

  task automatic test_reset;
    rst_n = 0; in_valid = 1; flush = 1; out_ready = 0;
    instruction_in = 32'h00500093; pc_in = 8'h10;
    tick; tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (instruction_out !== 32'h00000013) begin n_err++; $display("FAIL reset_instr: got %h want 00000013", instruction_out); end
    n_cmp++; if (pc_out !== 8'h00) begin n_err++; $display("FAIL reset_pc: got %h want 00", pc_out); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if (ctrl !== 7'b0010011 || fmt !== 3'd1 || imm !== 64'd0 || rd !== 5'd0 || rs1 !== 5'd0 || illegal !== 1'b0)
      begin n_err++; $display("FAIL reset_decode: got ctrl=%b fmt=%0d imm=%h rd=%0d rs1=%0d ill=%b want 0010011/1/0/0/0/0", ctrl, fmt, imm, rd, rs1, illegal); end
    rst_n = 1; in_valid = 0; flush = 0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_addi;
    do_reset;
    in_valid = 1; out_ready = 1; instruction_in = 32'h00500093; pc_in = 8'h04;
    tick;
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    n_cmp++; if (ctrl !== 7'b0010011 || fmt !== 3'd1 || rd !== 5'd1 || rs1 !== 5'd0)
      begin n_err++; $display("FAIL addi_fields: got ctrl=%b fmt=%0d rd=%0d rs1=%0d want 0010011/1/1/0", ctrl, fmt, rd, rs1); end
    n_cmp++; if (imm !== 64'd5) begin n_err++; $display("FAIL addi_imm: got %h want 5", imm); end
    n_cmp++; if (pc_out !== 8'h04) begin n_err++; $display("FAIL addi_pc: got %h want 04", pc_out); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    n_cmp++; if (instruction_out !== 32'h00500093) begin n_err++; $display("FAIL drain_hold: got %h want 00500093", instruction_out); end
  endtask

  task automatic test_beq;
    do_reset;
    in_valid = 1; out_ready = 1; instruction_in = 32'hFE208CE3; pc_in = 8'h20;
    tick;
    in_valid = 0;
    n_cmp++; if (fmt !== 3'd3 || rs1 !== 5'd1 || rs2 !== 5'd2 || funct3 !== 3'd0 || funct7 !== 7'h7F)
      begin n_err++; $display("FAIL beq_fields: got fmt=%0d rs1=%0d rs2=%0d f3=%0d f7=%h want 3/1/2/0/7f", fmt, rs1, rs2, funct3, funct7); end
    n_cmp++; if (imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_err++; $display("FAIL beq_imm: got %h want fffffffffffffff8", imm); end
  endtask

  task automatic test_stall;
    do_reset;
    in_valid = 1; out_ready = 1; instruction_in = 32'h00A00113; pc_in = 8'h08;
    tick;
    instruction_in = 32'h00F00193; pc_in = 8'h0C; out_ready = 0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b want 0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b1 || instruction_out !== 32'h00A00113 || pc_out !== 8'h08)
        begin n_err++; $display("FAIL stall_frozen%0d: got v=%b instr=%h pc=%h want 1/00a00113/08", k, out_valid, instruction_out, pc_out); end
    end
    n_cmp++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
    out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || instruction_out !== 32'h00F00193 || pc_out !== 8'h0C || rd !== 5'd3)
      begin n_err++; $display("FAIL stall_pending: got v=%b instr=%h pc=%h rd=%0d want 1/00f00193/0c/3", out_valid, instruction_out, pc_out, rd); end
    n_cmp++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL stall_cnt_after: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_flush;
    do_reset;
    in_valid = 1; out_ready = 1; instruction_in = 32'h00A00113; pc_in = 8'h08;
    tick;
    in_valid = 0; out_ready = 0;
    tick;
    in_valid = 1; flush = 1; instruction_in = 32'h00500093; pc_in = 8'h30;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick;
    flush = 0; in_valid = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_cmp++; if (instruction_out !== 32'h00000013 || pc_out !== 8'h00 || fmt !== 3'd1 || rd !== 5'd0 || imm !== 64'd0)
      begin n_err++; $display("FAIL flush_nop: got instr=%h pc=%h fmt=%0d rd=%0d imm=%h want 00000013/00/1/0/0", instruction_out, pc_out, fmt, rd, imm); end
    out_ready = 1;
    tick;
    n_cmp++; if (out_valid !== 1'b0 || instruction_out !== 32'h00000013)
      begin n_err++; $display("FAIL flush_dropped: got v=%b instr=%h want 0/00000013", out_valid, instruction_out); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ins [5];
    logic [2:0] fe [5];
    logic [63:0] ie [5];
    ins[0] = 32'h00500093; fe[0] = 3'd1; ie[0] = 64'd5;
    ins[1] = 32'h800000B7; fe[1] = 3'd4; ie[1] = 64'hFFFF_FFFF_8000_0000;
    ins[2] = 32'hFE20AE23; fe[2] = 3'd2; ie[2] = 64'hFFFF_FFFF_FFFF_FFFC;
    ins[3] = 32'h001000EF; fe[3] = 3'd5; ie[3] = 64'h800;
    ins[4] = 32'h002081B3; fe[4] = 3'd0; ie[4] = 64'd0;
    do_reset;
    out_ready = 1; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      instruction_in = ins[k]; pc_in = 8'(k * 4);
      tick;
      n_cmp++; if (out_valid !== 1'b1 || instruction_out !== ins[k] || pc_out !== 8'(k * 4) || fmt !== fe[k] || imm !== ie[k])
        begin n_err++; $display("FAIL b2b_%0d: got v=%b instr=%h pc=%h fmt=%0d imm=%h want 1/%h/%h/%0d/%h", k, out_valid, instruction_out, pc_out, fmt, imm, ins[k], 8'(k * 4), fe[k], ie[k]); end
    end
    in_valid = 0;
  endtask

  task automatic test_saturation_illegal;
    do_reset;
    in_valid = 1; out_ready = 1; instruction_in = 32'h00A00113; pc_in = 8'h08;
    tick;
    in_valid = 0; out_ready = 0;
    repeat (5) tick;
    n_cmp++; if (stall_cnt2 !== 2'd3) begin n_err++; $display("FAIL sat_cnt2: got %0d want 3", stall_cnt2); end
    n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL sat_cnt16: got %0d want 5", stall_cnt); end
    out_ready = 1; in_valid = 1; instruction_in = 32'hFFFFFFFF; pc_in = 8'h40;
    tick;
    in_valid = 0;
    n_cmp++; if (out_valid2 !== 1'b1 || fmt2 !== 3'd7 || illegal2 !== 1'b1 || imm2 !== 64'd0)
      begin n_err++; $display("FAIL illegal: got v=%b fmt=%0d ill=%b imm=%h want 1/7/1/0", out_valid2, fmt2, illegal2, imm2); end
    n_cmp++; if (pc_out2 !== 8'h40 || ctrl2 !== 7'h7F) begin n_err++; $display("FAIL illegal_payload: got pc=%h ctrl=%b want 40/1111111", pc_out2, ctrl2); end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_beq;
    test_stall;
    test_flush;
    test_back_to_back;
    test_saturation_illegal;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
